// File: rtl/cmos_capture.sv
// cmos_capture: samples an OV7670-style 8-bit camera bus, packs RGB565 byte pairs
// into RGB444 pixels and drives the frame-buffer write port in raster order.
// Three register stages: input sampling, byte pairing, write-port issue.
module cmos_capture #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int ADDR_W     = 19,
    parameter int MAX_PIXELS = H_ACTIVE * V_ACTIVE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture_en,
    input  logic              cmos_vsync,
    input  logic              cmos_href,
    input  logic [7:0]        cmos_data,
    output logic              write_en,
    output logic [ADDR_W-1:0] write_addr,
    output logic [11:0]       data_out,
    output logic              cmos_pixel_valid,
    output logic              frame_done,
    output logic              overflow,
    output logic [9:0]        line_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE
    } state_t;

    // Frame depth widened by one bit so the compare also works when
    // MAX_PIXELS equals 2**ADDR_W.
    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(MAX_PIXELS);

    // Input sampling registers and their one-cycle-delayed copies for edge detection.
    logic        r_vs_q;
    logic        r_vs_qq;
    logic        r_hr_q;
    logic        r_hr_qq;
    logic [7:0]  r_d_q;

    state_t      r_state;
    state_t      w_state_next;

    // Byte-pairing stage.
    logic        r_phase;      // 0 = expecting hi byte, 1 = expecting lo byte
    logic [6:0]  r_hi;         // hi byte bits {7:4, 2:0}; bit 3 is dropped by RGB444
    logic        r_wr_pend;    // one write scheduled for the issue stage
    logic        r_wr_valid;
    logic [11:0] r_wr_data;
    logic        r_end_pend;   // frame end scheduled for the issue stage

    // Issue stage.
    logic [ADDR_W-1:0] r_addr;

    logic w_vs_rise;
    logic w_vs_fall;
    logic w_hr_fall;
    logic w_active;
    logic w_frame_end;
    logic w_frame_start;
    logic w_in_range;

    assign w_vs_rise     = r_vs_q & ~r_vs_qq;
    assign w_vs_fall     = ~r_vs_q & r_vs_qq;
    assign w_hr_fall     = ~r_hr_q & r_hr_qq;
    // Bytes only count inside an active frame; href during blanking is ignored.
    assign w_active      = (r_state == ST_CAPTURE) & ~r_vs_q;
    assign w_frame_end   = (r_state == ST_CAPTURE) & w_vs_rise;
    assign w_frame_start = (r_state == ST_ARMED) & w_vs_fall;
    assign w_in_range    = {1'b0, r_addr} < MAX_CNT;

    // Register the camera pins once; everything downstream uses these copies.
    // NOTE: clocked state uses non-blocking (<=) so every register samples the
    // pre-edge value of every other register, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_q  <= 1'b0;
            r_vs_qq <= 1'b0;
            r_hr_q  <= 1'b0;
            r_hr_qq <= 1'b0;
            r_d_q   <= 8'd0;
        end else begin
            r_vs_q  <= cmos_vsync;
            r_vs_qq <= r_vs_q;
            r_hr_q  <= cmos_href;
            r_hr_qq <= r_hr_q;
            r_d_q   <= cmos_data;
        end
    end

    // Frame-sync state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: arm on a vsync rising edge, capture from the following falling
    // edge, so a frame is never joined part-way through.
    // NOTE: the default assignment first keeps every path assigned, so no latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (capture_en && w_vs_rise) w_state_next = ST_ARMED;
            ST_ARMED:   if (w_vs_fall) w_state_next = ST_CAPTURE;
            ST_CAPTURE: if (w_vs_rise) w_state_next = capture_en ? ST_ARMED : ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Pair href bytes into pixels, flush a dangling odd byte on href fall, count lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase    <= 1'b0;
            r_hi       <= 7'd0;
            r_wr_pend  <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_data  <= 12'd0;
            r_end_pend <= 1'b0;
            line_count <= 10'd0;
        end else begin
            r_wr_pend  <= 1'b0;
            r_end_pend <= w_frame_end;
            if (w_frame_end) begin
                r_phase <= 1'b0;
            end else if (w_active) begin
                if (r_hr_q) begin
                    if (!r_phase) begin
                        r_hi    <= {r_d_q[7:4], r_d_q[2:0]};
                        r_phase <= 1'b1;
                    end else begin
                        r_wr_pend  <= 1'b1;
                        r_wr_valid <= 1'b1;
                        r_wr_data  <= {r_hi[6:3], r_hi[2:0], r_d_q[7], r_d_q[4:1]};
                        r_phase    <= 1'b0;
                    end
                end else if (w_hr_fall && r_phase) begin
                    r_wr_pend  <= 1'b1;
                    r_wr_valid <= 1'b0;
                    r_wr_data  <= 12'd0;
                    r_phase    <= 1'b0;
                end
            end
            // Cleared together with frame_done so the final count stays visible
            // until the frame is closed.
            if (r_end_pend) begin
                line_count <= 10'd0;
            end else if (w_active && w_hr_fall && line_count != 10'h3FF) begin
                line_count <= line_count + 10'd1;
            end
        end
    end

    // Issue scheduled writes, guard the frame-buffer depth, close frames.
    // A frame end is scheduled one stage behind its trigger, so any write already
    // in flight leaves first and the address reset can never swallow it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_en         <= 1'b0;
            write_addr       <= '0;
            data_out         <= 12'd0;
            cmos_pixel_valid <= 1'b0;
            frame_done       <= 1'b0;
            overflow         <= 1'b0;
            r_addr           <= '0;
        end else begin
            write_en         <= 1'b0;
            cmos_pixel_valid <= 1'b0;
            data_out         <= 12'd0;
            frame_done       <= r_end_pend;
            if (r_end_pend) begin
                r_addr     <= '0;
                write_addr <= '0;
            end else if (r_wr_pend) begin
                if (w_in_range) begin
                    write_en         <= 1'b1;
                    write_addr       <= r_addr;
                    data_out         <= r_wr_data;
                    cmos_pixel_valid <= r_wr_valid;
                    r_addr           <= r_addr + 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end
            if (w_frame_start) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cmos_capture.sv
// Testbench for cmos_capture: drives directed and random camera frames on a small
// 8x4 geometry and compares every write against a byte-level reference model.
module tb_cmos_capture;

    localparam int H    = 8;
    localparam int V    = 4;
    localparam int AW   = 19;
    localparam int MAXP = H * V;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          capture_en;
    logic          cmos_vsync;
    logic          cmos_href;
    logic [7:0]    cmos_data;
    logic          write_en;
    logic [AW-1:0] write_addr;
    logic [11:0]   data_out;
    logic          cmos_pixel_valid;
    logic          frame_done;
    logic          overflow;
    logic [9:0]    line_count;

    cmos_capture #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .ADDR_W   (AW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .capture_en       (capture_en),
        .cmos_vsync       (cmos_vsync),
        .cmos_href        (cmos_href),
        .cmos_data        (cmos_data),
        .write_en         (write_en),
        .write_addr       (write_addr),
        .data_out         (data_out),
        .cmos_pixel_valid (cmos_pixel_valid),
        .frame_done       (frame_done),
        .overflow         (overflow),
        .line_count       (line_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        int valid;
        int cyc;
    } wr_t;

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    int  fd_count = 0;
    wr_t act_q[$];
    wr_t exp_q[$];
    wr_t mon_w;
    int  exp_addr = 0;
    bit  exp_ovf = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write strobe and every frame_done cycle, mid-cycle.
    always @(negedge clk) begin
        if (write_en === 1'b1) begin
            mon_w.addr  = int'(write_addr);
            mon_w.data  = int'(data_out);
            mon_w.valid = int'(cmos_pixel_valid);
            mon_w.cyc   = cyc;
            act_q.push_back(mon_w);
        end
        if (frame_done === 1'b1) fd_count++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // RGB565 -> RGB444 by keeping the top four bits of each colour field.
    function automatic logic [11:0] rgb444(input logic [7:0] hi, input logic [7:0] lo);
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
        r5 = hi[7:3];
        g6 = {hi[2:0], lo[7:5]};
        b5 = lo[4:0];
        return {r5[4:1], g6[5:2], b5[4:1]};
    endfunction

    function automatic void emit(input int data, input int valid, input int wcyc);
        wr_t e;
        if (exp_addr < MAXP) begin
            e.addr  = exp_addr;
            e.data  = data;
            e.valid = valid;
            e.cyc   = wcyc;
            exp_q.push_back(e);
            exp_addr++;
        end else begin
            exp_ovf = 1'b1;
        end
    endfunction

    // Drive one href burst, then let the pipeline settle.
    task automatic send_bytes(input logic [7:0] bytes[$], input bit model_on);
        int pair_cyc[$];
        int hf_cyc;
        for (int i = 0; i < bytes.size(); i++) begin
            @(negedge clk);
            cmos_href = 1'b1;
            cmos_data = bytes[i];
            if (i % 2 == 1) pair_cyc.push_back(cyc);
        end
        @(negedge clk);
        cmos_href = 1'b0;
        cmos_data = 8'd0;
        hf_cyc = cyc;
        repeat (4) @(negedge clk);
        if (model_on) begin
            // Written 2 edges after the byte is sampled: visible at drive cycle + 3.
            for (int p = 0; p < bytes.size() / 2; p++)
                emit(int'(rgb444(bytes[2*p], bytes[2*p+1])), 1, pair_cyc[p] + 3);
            if (bytes.size() % 2 == 1) emit(0, 0, hf_cyc + 3);
        end
    endtask

    task automatic rand_line(input int n, input bit model_on);
        logic [7:0] b[$];
        for (int i = 0; i < n; i++) b.push_back(8'($urandom));
        send_bytes(b, model_on);
    endtask

    // vsync high (with a stray href burst in blanking), then low to open a frame.
    task automatic start_frame(input bit cap, input string tag);
        @(negedge clk);
        cmos_vsync = 1'b1;
        rand_line(4, 1'b0);
        @(negedge clk);
        cmos_vsync = 1'b0;
        repeat (4) @(negedge clk);
        if (cap) exp_ovf = 1'b0;
        check({tag, "_start_ovf"}, overflow, exp_ovf);
    endtask

    task automatic end_frame(input int exp_done, input int exp_lines, input string tag);
        int fd0;
        int n;
        check({tag, "_lines"}, line_count, exp_lines);
        fd0 = fd_count;
        @(negedge clk);
        cmos_vsync = 1'b1;
        repeat (10) @(negedge clk);
        check({tag, "_done"}, fd_count - fd0, exp_done);
        check({tag, "_nwr"}, act_q.size(), exp_q.size());
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), act_q[i].addr, exp_q[i].addr);
            check($sformatf("%s_data%0d", tag, i), act_q[i].data, exp_q[i].data);
            check($sformatf("%s_vld%0d", tag, i), act_q[i].valid, exp_q[i].valid);
            check($sformatf("%s_cyc%0d", tag, i), act_q[i].cyc, exp_q[i].cyc);
        end
        check({tag, "_addr_rst"}, write_addr, 0);
        check({tag, "_lines_rst"}, line_count, 0);
        check({tag, "_ovf"}, overflow, exp_ovf);
        act_q.delete();
        exp_q.delete();
        exp_addr = 0;
    endtask

    initial begin
        logic [7:0] t1[$];
        rst_n      = 1'b0;
        capture_en = 1'b0;
        cmos_vsync = 1'b0;
        cmos_href  = 1'b0;
        cmos_data  = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_we", write_en, 0);
        check("rst_addr", write_addr, 0);
        check("rst_data", data_out, 0);
        check("rst_vld", cmos_pixel_valid, 0);
        check("rst_fd", frame_done, 0);
        check("rst_ovf", overflow, 0);
        check("rst_lines", line_count, 0);
        rst_n = 1'b1;
        capture_en = 1'b1;

        // Directed pair: F8,00 -> F00 and 07,E0 -> 0F0.
        start_frame(1'b1, "t1");
        t1 = '{8'hF8, 8'h00, 8'h07, 8'hE0};
        send_bytes(t1, 1'b1);
        check("t1_px0", (act_q.size() > 0) ? act_q[0].data : 32'hDEAD, 32'hF00);
        check("t1_px1", (act_q.size() > 1) ? act_q[1].data : 32'hDEAD, 32'h0F0);
        end_frame(1, 1, "t1");

        // Odd byte count: second write carries cmos_pixel_valid=0 and zero data.
        start_frame(1'b1, "odd");
        rand_line(3, 1'b1);
        end_frame(1, 1, "odd");

        // Exactly one full frame.
        start_frame(1'b1, "full");
        for (int l = 0; l < V; l++) rand_line(2 * H, 1'b1);
        check("full_last", (act_q.size() > 0) ? act_q[act_q.size()-1].addr : -1, MAXP - 1);
        end_frame(1, V, "full");

        // One line too many: suppressed writes, sticky overflow until next start.
        start_frame(1'b1, "ovf");
        for (int l = 0; l < V + 1; l++) rand_line(2 * H, 1'b1);
        check("ovf_flag", overflow, 1);
        end_frame(1, V + 1, "ovf");

        // Random line lengths, mixed odd/even.
        start_frame(1'b1, "rnd");
        for (int l = 0; l < 3; l++) rand_line(int'($urandom_range(1, 2 * H + 1)), 1'b1);
        end_frame(1, 3, "rnd");

        // Reset in the middle of a frame, released with vsync low.
        start_frame(1'b1, "mid");
        rand_line(2 * H, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_we", write_en, 0);
        check("mid_rst_addr", write_addr, 0);
        check("mid_rst_lines", line_count, 0);
        act_q.delete();
        exp_q.delete();
        exp_addr = 0;
        exp_ovf  = 1'b0;
        rst_n = 1'b1;
        rand_line(2 * H, 1'b0);
        rand_line(5, 1'b0);
        check("mid_nowr", act_q.size(), 0);
        check("mid_nolines", line_count, 0);
        start_frame(1'b1, "post");
        rand_line(2 * H, 1'b1);
        end_frame(1, 1, "post");

        // capture_en dropped during frame 2: it finishes, frame 3 is ignored.
        start_frame(1'b1, "f2");
        rand_line(2 * H, 1'b1);
        capture_en = 1'b0;
        rand_line(2 * H, 1'b1);
        end_frame(1, 2, "f2");
        start_frame(1'b0, "f3");
        rand_line(2 * H, 1'b0);
        rand_line(2 * H, 1'b0);
        end_frame(0, 0, "f3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
